// File: rtl/sigma_chien_search.sv
// Chien search over a Berlekamp-Massey error-locator polynomial in GF(2^8). It evaluates all 255 codeword positions.
// Latency: reads T+1 coefficients, then evaluates one position per cycle. done arrives 266 cycles after start (T=8).
// Backpressure: none. start is accepted only in IDLE, and each loc_valid pulse must be consumed when it appears.
// Ports: clock/reset; start, sigma_base, deg in; rdaddress/rden/q to the sigma buffer;
//        busy, loc_valid/loc_pos/loc_err per position, done/err_count/fail per block.
module sigma_chien_search #(
    parameter int T = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] sigma_base,
    input  logic [3:0] deg,
    output logic [7:0] rdaddress,
    output logic       rden,
    input  logic [7:0] q,
    output logic       busy,
    output logic       loc_valid,
    output logic [7:0] loc_pos,
    output logic       loc_err,
    output logic       done,
    output logic [3:0] err_count,
    output logic       fail
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_SEARCH, S_FINISH} state_t;

    state_t          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [7:0]      base_q, base_d;
    logic [3:0]      deg_q, deg_d;
    logic [T:0][7:0] r_q, r_d;
    logic [3:0]      root_cnt_q, root_cnt_d;
    logic [3:0]      err_count_q, err_count_d;
    logic            fail_q, fail_d;
    logic [7:0]      loc_pos_q, loc_pos_d;

    logic [7:0]      eval_sum;
    logic            root_hit;
    logic [7:0]      search_pos;
    logic [3:0]      root_cnt_inc;

    // Multiply by alpha modulo x^8+x^4+x^3+x^2+1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
    endfunction

    // Multiply by alpha^n. n is a constant per coefficient, so this reduces to a fixed XOR network.
    function automatic logic [7:0] mul_apow(input logic [7:0] a, input int n);
        logic [7:0] v;
        v = a;
        for (int i = 0; i < T; i++) begin
            if (i < n) v = xtime(v);
        end
        return v;
    endfunction

    // At step k the registers hold sigma_j * alpha^(j*k), so their XOR is sigma(alpha^k).
    always_comb begin
        eval_sum = 8'h00;
        for (int j = 0; j <= T; j++) eval_sum = eval_sum ^ r_q[j];
    end

    assign root_hit     = (eval_sum == 8'h00);
    // A root at alpha^k marks the error location alpha^-k, which is position (255-k) mod 255.
    assign search_pos   = (cnt_q == 8'd0) ? 8'd0 : 8'd255 - cnt_q;
    assign root_cnt_inc = (root_cnt_q == 4'hF) ? root_cnt_q : root_cnt_q + 4'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            base_q      <= '0;
            deg_q       <= '0;
            r_q         <= '0;
            root_cnt_q  <= '0;
            err_count_q <= '0;
            fail_q      <= 1'b0;
            loc_pos_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            base_q      <= base_d;
            deg_q       <= deg_d;
            r_q         <= r_d;
            root_cnt_q  <= root_cnt_d;
            err_count_q <= err_count_d;
            fail_q      <= fail_d;
            loc_pos_q   <= loc_pos_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_LOAD;
            S_LOAD:   if (cnt_q == 8'(T)) state_d = S_WAIT;
            S_WAIT:   state_d = S_SEARCH;
            S_SEARCH: if (cnt_q == 8'd254) state_d = S_FINISH;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        cnt_d       = cnt_q;
        base_d      = base_q;
        deg_d       = deg_q;
        r_d         = r_q;
        root_cnt_d  = root_cnt_q;
        err_count_d = err_count_q;
        fail_d      = fail_q;
        loc_pos_d   = loc_pos_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d     = sigma_base;
                    deg_d      = deg;
                    cnt_d      = 8'd0;
                    root_cnt_d = 4'd0;
                end
            end
            S_LOAD: begin
                cnt_d = (cnt_q == 8'(T)) ? 8'd0 : cnt_q + 8'd1;
                // q answers the read issued on the previous cycle, so it belongs to coefficient cnt-1.
                for (int j = 0; j < T; j++) begin
                    if (cnt_q == 8'(j + 1)) r_d[j] = (4'(j) <= deg_q) ? q : 8'h00;
                end
            end
            S_WAIT: begin
                r_d[T] = (4'(T) <= deg_q) ? q : 8'h00;
            end
            S_SEARCH: begin
                cnt_d     = cnt_q + 8'd1;
                loc_pos_d = search_pos;
                for (int j = 0; j <= T; j++) r_d[j] = mul_apow(r_q[j], j);
                if (root_hit) root_cnt_d = root_cnt_inc;
                // Publish the results on the last step so they are valid during the done cycle.
                if (cnt_q == 8'd254) begin
                    err_count_d = root_cnt_d;
                    fail_d      = (deg_q > 4'(T)) || (r_q[0] == 8'h00) || (root_cnt_d != deg_q);
                end
            end
            default: ;
        endcase
    end

    // Outputs
    always_comb begin
        busy      = 1'b0;
        rden      = 1'b0;
        rdaddress = 8'h00;
        loc_valid = 1'b0;
        loc_err   = 1'b0;
        done      = 1'b0;
        loc_pos   = loc_pos_q;
        case (state_q)
            S_LOAD: begin
                busy      = 1'b1;
                rden      = 1'b1;
                rdaddress = base_q + cnt_q;
            end
            S_WAIT: busy = 1'b1;
            S_SEARCH: begin
                busy      = 1'b1;
                loc_valid = 1'b1;
                loc_err   = root_hit;
                loc_pos   = search_pos;
            end
            S_FINISH: done = 1'b1;
            default: ;
        endcase
    end

    assign err_count = err_count_q;
    assign fail      = fail_q;

endmodule

// File: tb/tb_sigma_chien_search.sv
module tb_sigma_chien_search;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] sigma_base;
    logic [3:0] deg;
    logic [7:0] rdaddress;
    logic       rden;
    logic [7:0] q;
    logic       busy;
    logic       loc_valid;
    logic [7:0] loc_pos;
    logic       loc_err;
    logic       done;
    logic [3:0] err_count;
    logic       fail;

    always #5 clock = ~clock;

    sigma_chien_search #(.T(8)) dut (
        .clock(clock), .reset(reset), .start(start), .sigma_base(sigma_base), .deg(deg),
        .rdaddress(rdaddress), .rden(rden), .q(q), .busy(busy), .loc_valid(loc_valid),
        .loc_pos(loc_pos), .loc_err(loc_err), .done(done), .err_count(err_count), .fail(fail)
    );

    // Sigma buffer: registered read, data one cycle after rden.
    logic [7:0] mem [0:255];
    always @(posedge clock) if (rden) q <= mem[rdaddress];

    int alog [0:254];
    int checks = 0;
    int errors = 0;

    // Reference model state
    int cyc = 0;
    int n_start = 0;
    bit active = 1'b0;
    bit armed = 1'b0;
    int base_m = 0;
    int deg_m = 0;
    bit exp_err [0:254];
    int exp_cnt = 0;
    int exp_fail = 0;
    int hold_cnt = 0;
    int hold_fail = 0;
    int hold_lpos = 0;
    int nv_dut = 0;

    // Literal expectations for the directed scenarios
    bit lit_on = 1'b0;
    int lit_a = -1;
    int lit_b = -1;
    int lit_cnt = 0;
    int lit_fail = 0;
    int to_cnt = 0;
    int to_seen = 0;

    function automatic int gmul(int a, int b);
        int p;
        int x;
        int y;
        p = 0;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            y = y >> 1;
            x = x << 1;
            if (x[8]) x = x ^ 32'h11D;
        end
        return p;
    endfunction

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0h want %0h at cycle %0d", nm, a, e, cyc);
        end
    endtask

    // Evaluate sigma at every alpha^k directly, as a polynomial.
    task automatic build_model();
        int sg [0:8];
        int v;
        int c;
        for (int j = 0; j <= 8; j++) sg[j] = (j <= deg_m) ? int'(mem[(base_m + j) & 255]) : 0;
        c = 0;
        for (int k = 0; k < 255; k++) begin
            v = 0;
            for (int j = 0; j <= 8; j++) v = v ^ gmul(sg[j], alog[(j * k) % 255]);
            exp_err[k] = (v == 0);
            if (v == 0) c++;
        end
        exp_cnt  = (c > 15) ? 15 : c;
        exp_fail = (deg_m > 8 || sg[0] == 0 || exp_cnt != deg_m) ? 1 : 0;
    endtask

    // Single compare process: check cycle `cyc`, then apply this cycle's inputs to the model.
    always @(negedge clock) begin : cmp
        int d;
        int k;
        int e_pos;
        bit e_rden;
        bit e_busy;
        bit e_vld;
        bit e_done;
        bit e_err;
        if (armed) begin
            d      = cyc - n_start;
            e_rden = active && d >= 1 && d <= 9;
            e_busy = active && d >= 1 && d <= 265;
            e_vld  = active && d >= 11 && d <= 265;
            e_done = active && d == 266;
            e_err  = 1'b0;
            e_pos  = hold_lpos;
            if (e_vld) begin
                k         = d - 11;
                e_pos     = (k == 0) ? 0 : 255 - k;
                hold_lpos = e_pos;
                e_err     = exp_err[k];
            end
            if (e_done) begin
                hold_cnt  = exp_cnt;
                hold_fail = exp_fail;
            end
            chk("rden", 32'(rden), 32'(e_rden));
            if (e_rden) chk("rdaddress", 32'(rdaddress), 32'((base_m + d - 1) & 255));
            else if (!active) chk("rdaddress_idle", 32'(rdaddress), 32'(0));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("loc_valid", 32'(loc_valid), 32'(e_vld));
            chk("loc_err", 32'(loc_err), 32'(e_err));
            chk("loc_pos", 32'(loc_pos), 32'(e_pos));
            chk("done", 32'(done), 32'(e_done));
            chk("err_count", 32'(err_count), 32'(hold_cnt));
            chk("fail", 32'(fail), 32'(hold_fail));
            chk("timeout", 32'(to_cnt), 32'(to_seen));
            to_seen = to_cnt;
            if (loc_valid === 1'b1) nv_dut++;
            if (lit_on && e_vld)
                chk("lit_loc_err", 32'(loc_err), 32'((e_pos == lit_a || e_pos == lit_b) ? 1 : 0));
            if (lit_on && e_done) begin
                chk("lit_err_count", 32'(err_count), 32'(lit_cnt));
                chk("lit_fail", 32'(fail), 32'(lit_fail));
                chk("model_count", 32'(exp_cnt), 32'(lit_cnt));
                chk("lit_valid_pulses", 32'(nv_dut), 32'(255));
                if (lit_a >= 0) chk("model_root", 32'(exp_err[(255 - lit_a) % 255]), 32'(1));
            end
        end
        if (reset === 1'b1) begin
            armed     = 1'b1;
            active    = 1'b0;
            hold_cnt  = 0;
            hold_fail = 0;
            hold_lpos = 0;
        end else if (armed && start === 1'b1 && (!active || cyc - n_start >= 267)) begin
            active  = 1'b1;
            n_start = cyc;
            base_m  = int'(sigma_base);
            deg_m   = int'(deg);
            nv_dut  = 0;
            build_model();
        end
        cyc++;
    end

    task automatic pulse_start(input logic [7:0] b, input logic [3:0] dg);
        @(posedge clock);
        #1;
        start      = 1'b1;
        sigma_base = b;
        deg        = dg;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 400 && !seen; n++) begin
            @(negedge clock);
            if (done === 1'b1) seen = 1'b1;
        end
        if (!seen) to_cnt++;
        @(posedge clock);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic set_lit(input int a, input int b, input int c, input int f);
        lit_a    = a;
        lit_b    = b;
        lit_cnt  = c;
        lit_fail = f;
        lit_on   = 1'b1;
    endtask

    int sg [0:8];
    int ne;
    int p0;
    int step;
    int b;

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        sigma_base = 8'h00;
        deg        = 4'd0;
        alog[0]    = 1;
        for (int i = 1; i < 255; i++) alog[i] = gmul(alog[i - 1], 2);
        clear_mem();
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // sigma = 1: no roots at all
        clear_mem();
        mem[8'h00] = 8'h01;
        set_lit(-1, -1, 0, 0);
        pulse_start(8'h00, 4'd0);
        wait_done();
        lit_on = 1'b0;

        // sigma = 1 + alpha^5 x: single error at position 5
        mem[8'h10] = 8'h01; mem[8'h11] = 8'h20;
        set_lit(5, -1, 1, 0);
        pulse_start(8'h10, 4'd1);
        wait_done();
        lit_on = 1'b0;

        // sigma = (1+x)(1+alpha x): errors at positions 0 and 1
        mem[8'h30] = 8'h01; mem[8'h31] = 8'h03; mem[8'h32] = 8'h02;
        set_lit(0, 1, 2, 0);
        pulse_start(8'h30, 4'd2);
        wait_done();
        lit_on = 1'b0;

        // Degree claims 2 but only one root exists
        mem[8'h50] = 8'h01; mem[8'h51] = 8'h20; mem[8'h52] = 8'h00;
        set_lit(5, -1, 1, 1);
        pulse_start(8'h50, 4'd2);
        wait_done();
        lit_on = 1'b0;

        // Address wrap, plus start pulses during the search and in the done cycle
        for (int j = 0; j < 9; j++) mem[(252 + j) & 255] = 8'($urandom_range(0, 255));
        pulse_start(8'hFC, 4'($urandom_range(0, 8)));
        repeat (48) @(posedge clock);
        pulse_start(8'h30, 4'd2);
        repeat (214) @(posedge clock);
        pulse_start(8'h30, 4'd2);
        repeat (3) @(posedge clock);

        // Reset in the middle of LOAD
        pulse_start(8'h30, 4'd2);
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        @(posedge clock);

        // Reset in the middle of SEARCH, then a restart two cycles later
        pulse_start(8'h10, 4'd1);
        repeat (98) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        @(posedge clock);
        pulse_start(8'h10, 4'd1);
        wait_done();

        // Random polynomials. Odd iterations build sigma from real error positions.
        for (int it = 0; it < 6; it++) begin
            b = $urandom_range(0, 255);
            if (it % 2 == 1) begin
                ne   = $urandom_range(0, 8);
                p0   = $urandom_range(0, 254);
                step = $urandom_range(1, 30);
                for (int j = 0; j <= 8; j++) sg[j] = (j == 0) ? 1 : 0;
                for (int i = 0; i < ne; i++)
                    for (int j = 8; j >= 1; j--)
                        sg[j] = sg[j] ^ gmul(sg[j - 1], alog[(p0 + i * step) % 255]);
            end else begin
                ne = $urandom_range(0, 15);
                for (int j = 0; j <= 8; j++) sg[j] = $urandom_range(0, 255);
            end
            for (int j = 0; j <= 8; j++) mem[(b + j) & 255] = 8'(sg[j]);
            pulse_start(8'(b), 4'(ne));
            wait_done();
        end

        repeat (4) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
